bp_watch_unit: RTL

- Parametrised breakpoint/watchpoint unit on the 16-bit data / 32-bit word-address memory bus.
- Successor to the fixed 4-entry exact-match breakpoint logic in the memory decoder. Adds:
  - N channels
  - address masks
  - per-channel fetch/read/write qualification
  - pass counters
  - sticky status
  - a halt request/acknowledge handshake
- Monitors the CPU access stream, raises halt_req to the control unit and supplies the handler vector.

---
 rtl/bp_watch_pkg.sv | 46 ++++
 rtl/bp_watch_unit_if.sv | 40 ++++
 rtl/bp_watch_chan.sv | 115 +++++++++++
 rtl/bp_watch_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bp_watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_watch_pkg
//  Description : Shared constants for the breakpoint/watchpoint unit:
//                register offsets, channel stride, access-kind encodings,
//                CTRL bit positions and the halt FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_watch_pkg;

    // Word stride between consecutive channel register blocks
    localparam int c_chan_stride = 8;

    // Per-channel register offsets (low 3 bits of the word offset)
    localparam logic [2:0] c_reg_ctrl    = 3'd0;
    localparam logic [2:0] c_reg_cmp_lo  = 3'd1;
    localparam logic [2:0] c_reg_cmp_hi  = 3'd2;
    localparam logic [2:0] c_reg_mask_lo = 3'd3;
    localparam logic [2:0] c_reg_mask_hi = 3'd4;
    localparam logic [2:0] c_reg_pass    = 3'd5;
    localparam logic [2:0] c_reg_hits    = 3'd6;

    // Global register offsets, relative to the block after the last channel
    localparam logic [2:0] c_reg_status  = 3'd0;
    localparam logic [2:0] c_reg_vec_lo  = 3'd1;
    localparam logic [2:0] c_reg_vec_hi  = 3'd2;
    localparam logic [2:0] c_reg_gctrl   = 3'd3;

    // Monitored access kinds (2'b11 never matches)
    localparam logic [1:0] c_kind_fetch  = 2'b00;
    localparam logic [1:0] c_kind_read   = 2'b01;
    localparam logic [1:0] c_kind_write  = 2'b10;

    // CTRL bit positions
    localparam int c_ctrl_en    = 0;
    localparam int c_ctrl_fetch = 1;
    localparam int c_ctrl_read  = 2;
    localparam int c_ctrl_write = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALT = 1'b1
    } bp_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_watch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : bp_watch_unit_if
//  Description : Register-window bus, monitored access stream and halt
//                handshake of the breakpoint/watchpoint unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bp_watch_unit_if;
    logic [31:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic        bus_sel;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;
    logic [31:0] mon_addr;
    logic [1:0]  mon_kind;
    logic        mon_valid;
    logic        halt_req;
    logic        halt_ack;
    logic [3:0]  bp_id;
    logic [31:0] bp_vector;

    // CPU / control-unit side
    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        output mon_addr, mon_kind, mon_valid, halt_ack,
        input  bus_sel, bus_rdata, bus_rvalid,
        input  halt_req, bp_id, bp_vector
    );

    // Breakpoint unit side
    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        input  mon_addr, mon_kind, mon_valid, halt_ack,
        output bus_sel, bus_rdata, bus_rvalid,
        output halt_req, bp_id, bp_vector
    );
endinterface
`default_nettype wire

// File: rtl/bp_watch_chan.sv
`default_nettype none
// ============================================================================
//  Module      : bp_watch_chan
//  Description : One comparator channel: CTRL/CMP/MASK/PASS/HITS registers,
//                masked address comparator and saturating pass counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_watch_chan
    import bp_watch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_g_en,
    input  logic              i_wr_en,
    input  logic [2:0]        i_wr_off,
    input  logic [15:0]       i_wdata,
    input  logic [2:0]        i_rd_off,
    output logic [15:0]       o_rd_data,
    input  logic              i_mon_valid,
    input  logic [31:0]       i_mon_addr,
    input  logic [1:0]        i_mon_kind,
    output logic              o_fire
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [31:0]      cmp_q, cmp_d;
    logic [31:0]      mask_q, mask_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] hits_q, hits_d;

    logic             w_kind_ok;
    logic             w_match;
    logic [CNT_W:0]   w_hits_inc;
    logic [CNT_W:0]   w_pass_eff;

    // Access-kind qualification against the CTRL enables
    always_comb begin
        w_kind_ok = 1'b0;
        case (i_mon_kind)
            c_kind_fetch: w_kind_ok = ctrl_q[c_ctrl_fetch];
            c_kind_read:  w_kind_ok = ctrl_q[c_ctrl_read];
            c_kind_write: w_kind_ok = ctrl_q[c_ctrl_write];
            default:      w_kind_ok = 1'b0;
        endcase
    end

    assign w_match = i_mon_valid & i_g_en & ctrl_q[c_ctrl_en] & w_kind_ok &
                     (((i_mon_addr ^ cmp_q) & mask_q) == 32'h0);

    // Extra bit keeps the +1 from wrapping; PASS of 0 behaves as 1
    assign w_hits_inc = {1'b0, hits_q} + (CNT_W+1)'(1);
    assign w_pass_eff = (pass_q == '0) ? (CNT_W+1)'(1) : {1'b0, pass_q};
    assign o_fire     = w_match & (w_hits_inc >= w_pass_eff);

    // Register writes and hit counting; HITS is not bus-writable
    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        mask_d = mask_q;
        pass_d = pass_q;
        hits_d = hits_q;
        if (i_wr_en) begin
            case (i_wr_off)
                c_reg_ctrl:    ctrl_d         = i_wdata[3:0];
                c_reg_cmp_lo:  cmp_d[15:0]    = i_wdata;
                c_reg_cmp_hi:  cmp_d[31:16]   = i_wdata;
                c_reg_mask_lo: mask_d[15:0]   = i_wdata;
                c_reg_mask_hi: mask_d[31:16]  = i_wdata;
                c_reg_pass:    pass_d         = i_wdata[CNT_W-1:0];
                default:       ;
            endcase
        end
        if (o_fire) begin
            hits_d = '0;
        end else if (w_match && (hits_q != '1)) begin
            hits_d = w_hits_inc[CNT_W-1:0];
        end
    end

    // Channel register file
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q <= '0;
            cmp_q  <= '0;
            mask_q <= '0;
            pass_q <= (CNT_W)'(1);
            hits_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cmp_q  <= cmp_d;
            mask_q <= mask_d;
            pass_q <= pass_d;
            hits_q <= hits_d;
        end
    end

    // Read-back of the addressed channel register
    always_comb begin
        o_rd_data = 16'h0000;
        case (i_rd_off)
            c_reg_ctrl:    o_rd_data = {12'h000, ctrl_q};
            c_reg_cmp_lo:  o_rd_data = cmp_q[15:0];
            c_reg_cmp_hi:  o_rd_data = cmp_q[31:16];
            c_reg_mask_lo: o_rd_data = mask_q[15:0];
            c_reg_mask_hi: o_rd_data = mask_q[31:16];
            c_reg_pass:    o_rd_data = 16'(pass_q);
            c_reg_hits:    o_rd_data = 16'(hits_q);
            default:       o_rd_data = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bp_watch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bp_watch_unit
//  Description : N-channel breakpoint/watchpoint unit. Channel comparators,
//                global STATUS/VEC/GCTRL registers, lowest-index priority
//                encoder, halt request FSM and registered bus read mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_watch_unit
    import bp_watch_pkg::*;
#(
    parameter int          CHANNELS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFF000,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] RESET_VEC = 32'h00000000
) (
    input  logic           clk,
    input  logic           rst,
    bp_watch_unit_if.slave bus
);

    // Block index of the global registers and last implemented word offset
    localparam logic [4:0] c_glb_idx  = 5'(CHANNELS);
    localparam logic [7:0] c_win_last = 8'(c_chan_stride * CHANNELS + 3);

    logic                w_in_win;
    logic [4:0]          w_idx;
    logic [2:0]          w_k;
    logic                w_glb_wr;
    logic [CHANNELS-1:0] w_fire;
    logic [15:0]         w_chan_rdata [CHANNELS];
    logic [3:0]          w_lowest;

    logic [CHANNELS-1:0] status_q, status_d;
    logic [31:0]         vec_q, vec_d;
    logic                gctrl_q, gctrl_d;
    bp_state_e           state_q, state_d;
    logic [3:0]          bp_id_q, bp_id_d;
    logic [31:0]         bp_vector_q, bp_vector_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    // Window is 256-word aligned, so the upper address bits identify it
    assign w_in_win = (bus.bus_addr[31:8] == BASE_ADDR[31:8]) &&
                      (bus.bus_addr[7:0] <= c_win_last);
    assign w_idx    = bus.bus_addr[7:3];
    assign w_k      = bus.bus_addr[2:0];
    assign w_glb_wr = bus.bus_we && w_in_win && (w_idx == c_glb_idx);

    assign bus.bus_sel    = w_in_win;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign bus.halt_req   = (state_q == ST_HALT);
    assign bus.bp_id      = bp_id_q;
    assign bus.bp_vector  = bp_vector_q;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            bp_watch_chan #(
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .i_g_en      (gctrl_q),
                .i_wr_en     (bus.bus_we && w_in_win && (w_idx == 5'(c))),
                .i_wr_off    (w_k),
                .i_wdata     (bus.bus_wdata),
                .i_rd_off    (w_k),
                .o_rd_data   (w_chan_rdata[c]),
                .i_mon_valid (bus.mon_valid),
                .i_mon_addr  (bus.mon_addr),
                .i_mon_kind  (bus.mon_kind),
                .o_fire      (w_fire[c])
            );
        end
    endgenerate

    // Lowest firing channel wins the bp_id slot
    always_comb begin
        w_lowest = 4'h0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_fire[c]) w_lowest = 4'(c);
        end
    end

    // Global registers; a fire on a STATUS bit overrides a same-cycle clear
    always_comb begin
        status_d = status_q;
        vec_d    = vec_q;
        gctrl_d  = gctrl_q;
        if (w_glb_wr) begin
            case (w_k)
                c_reg_status: status_d      = status_q & ~bus.bus_wdata[CHANNELS-1:0];
                c_reg_vec_lo: vec_d[15:0]   = bus.bus_wdata;
                c_reg_vec_hi: vec_d[31:16]  = bus.bus_wdata;
                c_reg_gctrl:  gctrl_d       = bus.bus_wdata[0];
                default:      ;
            endcase
        end
        status_d = status_d | w_fire;
    end

    // Halt FSM: capture id/vector on entry, hold until acknowledged
    always_comb begin
        state_d     = state_q;
        bp_id_d     = bp_id_q;
        bp_vector_d = bp_vector_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_fire) begin
                    state_d     = ST_HALT;
                    bp_id_d     = w_lowest;
                    bp_vector_d = vec_q;
                end
            end
            ST_HALT: begin
                if (bus.halt_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux; data holds between reads, valid pulses for one cycle
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (bus.bus_re && w_in_win) begin
            rvalid_d = 1'b1;
            rdata_d  = 16'h0000;
            if (w_idx == c_glb_idx) begin
                case (w_k)
                    c_reg_status: rdata_d = 16'(status_q);
                    c_reg_vec_lo: rdata_d = vec_q[15:0];
                    c_reg_vec_hi: rdata_d = vec_q[31:16];
                    c_reg_gctrl:  rdata_d = {15'h0000, gctrl_q};
                    default:      rdata_d = 16'h0000;
                endcase
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_idx == 5'(c)) rdata_d = w_chan_rdata[c];
                end
            end
        end
    end

    // Top-level state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q    <= '0;
            vec_q       <= RESET_VEC;
            gctrl_q     <= 1'b1;
            state_q     <= ST_IDLE;
            bp_id_q     <= 4'h0;
            bp_vector_q <= RESET_VEC;
            rdata_q     <= 16'h0000;
            rvalid_q    <= 1'b0;
        end else begin
            status_q    <= status_d;
            vec_q       <= vec_d;
            gctrl_q     <= gctrl_d;
            state_q     <= state_d;
            bp_id_q     <= bp_id_d;
            bp_vector_q <= bp_vector_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule
`default_nettype wire
